iter_shifter: RTL and testbench

Parametrised multi-cycle shifter for the CPU execute stage. It covers logical left, logical right, arithmetic right and rotate right. It replaces the fixed 32-bit, single-position arithmetic-right stage by iterating a STEP-bit shift stage over a registered accumulator. Interface is a start/busy/result_valid handshake, so the ALU stall logic can hold the pipeline while a shift completes.

---
 rtl/shifter_pkg.sv | 18 +
 rtl/shift_step.sv | 43 ++++
 rtl/iter_shifter.sv | 105 ++++++++++
 tb/tb_iter_shifter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative execute-stage shifter.
// Op codes match the ALU funct decode; states drive the shifter FSM.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } sh_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational shift stage: applies 0..STEP single-position shifts
// of the selected op to one operand.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int AMT_W = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] f
);

  function automatic logic [WIDTH-1:0] one(
    input logic [WIDTH-1:0] v,
    input logic [1:0]       o
  );
    logic [WIDTH-1:0] r;
    r = v;
    unique case (o)
      SH_SLL: r = {v[WIDTH-2:0], 1'b0};
      SH_SRL: r = {1'b0, v[WIDTH-1:1]};
      SH_SRA: r = {v[WIDTH-1], v[WIDTH-1:1]};
      SH_ROR: r = {v[0], v[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] acc;

  // Chain of single-position stages, each enabled while below amt.
  always_comb begin
    acc = in;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(amt)) acc = one(acc, op);
    end
  end

  assign f = acc;

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: iterates shift_step over a registered accumulator
// under a start/busy/result_valid handshake.
module iter_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               result_valid,
  output logic [WIDTH-1:0]   result
);

  localparam int AMT_W = $clog2(STEP + 1);

  state_e             state_q;
  sh_op_e             op_q;
  logic [WIDTH-1:0]   acc_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               busy_q;
  logic               valid_q;
  logic [WIDTH-1:0]   result_q;

  logic [SHAMT_W-1:0] step_c;
  logic [SHAMT_W-1:0] amt_d;
  logic [SHAMT_W-1:0] cnt_d;
  logic [WIDTH-1:0]   acc_d;

  assign step_c = SHAMT_W'(STEP);
  assign amt_d  = (cnt_q < step_c) ? cnt_q : step_c;
  assign cnt_d  = cnt_q - amt_d;

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AMT_W (AMT_W)
  ) u_step (
    .in  (acc_q),
    .op  (op_q),
    .amt (amt_d[AMT_W-1:0]),
    .f   (acc_d)
  );

  // Out-of-range amounts need no special case: iterating past WIDTH
  // saturates to all-fill, and rotation is periodic in WIDTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= SH_SLL;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q  <= data_in;
            cnt_q  <= shamt;
            op_q   <= sh_op_e'(op);
            busy_q <= 1'b1;
            if (shamt == '0) begin
              state_q  <= S_DONE;
              valid_q  <= 1'b1;
              result_q <= data_in;
            end else begin
              state_q <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          if (cnt_d == '0) begin
            state_q  <= S_DONE;
            valid_q  <= 1'b1;
            result_q <= acc_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign result       = result_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter across three parameter sets.
// Expected results and latencies are hand-computed constants.
module tb_iter_shifter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  op_r  = 2'b00;
  logic [31:0] data_r = '0;
  logic [4:0]  sh_r  = '0;
  logic        s32 = 1'b0;
  logic        s4  = 1'b0;
  logic        s16 = 1'b0;

  logic        b32, v32, b4, v4, b16, v16;
  logic [31:0] r32, r4;
  logic [15:0] r16;

  int checks = 0;
  int errors = 0;
  int lat, pulses, vlat, seen;

  always #5 clock = ~clock;

  iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u32 (
    .clock(clock), .reset(reset), .start(s32), .op(op_r),
    .data_in(data_r), .shamt(sh_r),
    .busy(b32), .result_valid(v32), .result(r32)
  );

  iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u4 (
    .clock(clock), .reset(reset), .start(s4), .op(op_r),
    .data_in(data_r), .shamt(sh_r),
    .busy(b4), .result_valid(v4), .result(r4)
  );

  iter_shifter #(.WIDTH(16), .SHAMT_W(4), .STEP(2)) u16 (
    .clock(clock), .reset(reset), .start(s16), .op(op_r),
    .data_in(data_r[15:0]), .shamt(sh_r[3:0]),
    .busy(b16), .result_valid(v16), .result(r16)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic vld(input int w);
    case (w)
      0:       return v32;
      1:       return v4;
      default: return v16;
    endcase
  endfunction

  function automatic logic [31:0] res(input int w);
    case (w)
      0:       return r32;
      1:       return r4;
      default: return {16'h0, r16};
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      0:       s32 = v;
      1:       s4  = v;
      default: s16 = v;
    endcase
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic go(input int w, input string tag, input logic [1:0] o,
                    input logic [31:0] d, input logic [4:0] s,
                    input logic [31:0] er, input int el);
    int l;
    op_r = o;
    data_r = d;
    sh_r = s;
    set_start(w, 1'b1);
    @(posedge clock); #1;
    set_start(w, 1'b0);
    l = 1;
    while (!vld(w) && l < 100) begin
      @(posedge clock); #1;
      l++;
    end
    chk({tag, "_valid"}, 32'(vld(w)), 32'd1);
    chk({tag, "_lat"}, 32'(l), 32'(el));
    chk({tag, "_res"}, res(w), er);
    @(posedge clock); #1;
    chk({tag, "_pulse1"}, 32'(vld(w)), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", 32'(b32), 32'd0);
    chk("rst_valid", 32'(v32), 32'd0);
    chk("rst_result", r32, 32'd0);
    reset = 1'b0;

    go(0, "ror0", 2'b11, 32'hDEADBEEF, 5'd0, 32'hDEADBEEF, 1);
    go(0, "ror1", 2'b11, 32'h00000001, 5'd1, 32'h80000000, 2);

    op_r = 2'b10;
    data_r = 32'h80000000;
    sh_r = 5'd20;
    s32 = 1'b1;
    @(posedge clock); #1;
    s32 = 1'b0;
    repeat (5) @(posedge clock);
    #4;
    reset = 1'b1;
    #1;
    chk("rstmid_busy", 32'(b32), 32'd0);
    chk("rstmid_result", r32, 32'd0);
    chk("rstmid_valid", 32'(v32), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clock); #1;
      if (v32) seen++;
    end
    chk("rstmid_novalid", 32'(seen), 32'd0);

    go(0, "sll4", 2'b00, 32'h00000001, 5'd4, 32'h00000010, 5);
    go(0, "sra31", 2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF, 32);
    go(0, "srl31", 2'b01, 32'h80000000, 5'd31, 32'h00000001, 32);
    go(1, "sra7_s4", 2'b10, 32'hF0000000, 5'd7, 32'hFFE00000, 3);
    go(2, "sra15_w16", 2'b10, 32'h00008001, 5'd15, 32'h0000FFFF, 9);

    op_r = 2'b00;
    data_r = 32'h3;
    sh_r = 5'd10;
    s32 = 1'b1;
    @(posedge clock); #1;
    lat = 1;
    pulses = 0;
    vlat = 0;
    while (lat < 60) begin
      if (v32) begin
        pulses++;
        vlat = lat;
      end
      if (!b32) break;
      s32 = 1'b1;
      op_r = 2'b01;
      data_r = 32'h0000FFFF;
      sh_r = 5'd1;
      @(posedge clock); #1;
      lat++;
    end
    s32 = 1'b0;
    chk("hs_pulses", 32'(pulses), 32'd1);
    chk("hs_lat", 32'(vlat), 32'd11);
    chk("hs_result", r32, 32'h00000C00);
    repeat (5) begin
      @(posedge clock); #1;
      chk("hs_hold", r32, 32'h00000C00);
      chk("hs_idle", {30'd0, b32, v32}, 32'd0);
    end
    op_r = 2'b01;
    data_r = 32'h00000100;
    sh_r = 5'd8;
    s32 = 1'b1;
    @(posedge clock); #1;
    s32 = 1'b0;
    chk("hs_accept", 32'(b32), 32'd1);
    seen = 0;
    repeat (20) begin
      if (!seen[0] && v32) begin
        seen = 1;
        chk("hs_next_res", r32, 32'h00000001);
      end
      @(posedge clock); #1;
    end
    chk("hs_next_done", 32'(seen), 32'd1);

    go(0, "after_hs", 2'b00, 32'h0000000F, 5'd2, 32'h0000003C, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
